// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
interface fetch_unit_if #(
  parameter int unsigned PC_W   = 16,
  parameter int unsigned INST_W = 32
);
  logic              req;
  logic [PC_W-1:0]   addr;
  logic              ack;
  logic [INST_W-1:0] data;

  modport master (output req, output addr, input ack, input data);
  modport slave  (input req, input addr, output ack, output data);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches over a req/ack bus and
// feeds IF/ID, with stall, redirect and a one-entry skid buffer.
module fetch_unit #(
  parameter int unsigned     PC_W     = 16,
  parameter int unsigned     INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  fetch_unit_if.master       imem,
  output logic               inst_valid_o,
  output logic [INST_W-1:0]  inst_o,
  output logic [PC_W-1:0]    pcp_o
);

  localparam logic [PC_W-1:0] INC = PC_W'(4);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD, DROP} state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic [PC_W-1:0]   addr_q, addr_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [PC_W-1:0]   pcp_q, pcp_d;
  logic [INST_W-1:0] skid_inst_q, skid_inst_d;
  logic [PC_W-1:0]   skid_pcp_q, skid_pcp_d;

  logic accept_c;
  logic consume_c;
  logic out_free_c;

  assign accept_c   = req_q & imem.ack;
  assign consume_c  = valid_q & ~stall_i;
  assign out_free_c = ~valid_q | consume_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; the skid is full exactly when in HOLD
  always_comb begin
    state_d = state_q;
    if (redirect_i) begin
      if ((state_q == BUSY || state_q == DROP) && !accept_c) state_d = DROP;
      else                                                    state_d = BUSY;
    end else begin
      unique case (state_q)
        IDLE:    state_d = BUSY;
        BUSY:    if (accept_c && !out_free_c) state_d = HOLD;
        HOLD:    if (consume_c) state_d = BUSY;
        DROP:    if (accept_c) state_d = BUSY;
        default: state_d = IDLE;
      endcase
    end
  end

  // Next values of the registered datapath/outputs
  always_comb begin
    req_d       = req_q;
    addr_d      = addr_q;
    pc_d        = pc_q;
    valid_d     = valid_q & ~consume_c;
    inst_d      = inst_q;
    pcp_d       = pcp_q;
    skid_inst_d = skid_inst_q;
    skid_pcp_d  = skid_pcp_q;
    if (redirect_i) begin
      // Unaccepted in-flight request keeps req/addr until its ack (DROP)
      valid_d = 1'b0;
      pc_d    = redirect_pc_i;
      if (state_q == IDLE || state_q == HOLD || accept_c) begin
        req_d  = 1'b1;
        addr_d = redirect_pc_i;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          req_d  = 1'b1;
          addr_d = pc_q;
        end
        BUSY: begin
          if (accept_c) begin
            pc_d = addr_q + INC;
            if (out_free_c) begin
              inst_d  = imem.data;
              pcp_d   = addr_q + INC;
              valid_d = 1'b1;
              addr_d  = addr_q + INC;
            end else begin
              skid_inst_d = imem.data;
              skid_pcp_d  = addr_q + INC;
              req_d       = 1'b0;
            end
          end
        end
        HOLD: begin
          if (consume_c) begin
            inst_d  = skid_inst_q;
            pcp_d   = skid_pcp_q;
            valid_d = 1'b1;
            req_d   = 1'b1;
            addr_d  = pc_q;
          end
        end
        DROP: begin
          if (accept_c) addr_d = pc_q;
        end
        default: begin
          req_d = 1'b0;
        end
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q       <= 1'b0;
      addr_q      <= '0;
      pc_q        <= RESET_PC;
      valid_q     <= 1'b0;
      inst_q      <= '0;
      pcp_q       <= '0;
      skid_inst_q <= '0;
      skid_pcp_q  <= '0;
    end else begin
      req_q       <= req_d;
      addr_q      <= addr_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      inst_q      <= inst_d;
      pcp_q       <= pcp_d;
      skid_inst_q <= skid_inst_d;
      skid_pcp_q  <= skid_pcp_d;
    end
  end

  assign imem.req     = req_q;
  assign imem.addr    = addr_q;
  assign inst_valid_o = valid_q;
  assign inst_o       = inst_q;
  assign pcp_o        = pcp_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall/skid, redirect/DROP,
// address wrap and asynchronous reset.
module tb_fetch_unit;
  localparam int unsigned PC_W   = 16;
  localparam int unsigned INST_W = 32;

  logic              clk, rst, rst2, stall, redirect;
  logic [PC_W-1:0]   redirect_pc;
  logic              v1, v2;
  logic [INST_W-1:0] i1, i2;
  logic [PC_W-1:0]   p1, p2;
  int                checks, errors;

  fetch_unit_if #(.PC_W(PC_W), .INST_W(INST_W)) m1 ();
  fetch_unit_if #(.PC_W(PC_W), .INST_W(INST_W)) m2 ();

  // Memory returns the address as the instruction word
  assign m1.data = INST_W'(m1.addr);
  assign m2.data = INST_W'(m2.addr);

  fetch_unit #(.PC_W(PC_W), .INST_W(INST_W), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .imem(m1.master),
    .inst_valid_o(v1), .inst_o(i1), .pcp_o(p1)
  );

  fetch_unit #(.PC_W(PC_W), .INST_W(INST_W), .RESET_PC(16'hFFF8)) dut2 (
    .clk(clk), .rst(rst2), .stall_i(stall), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .imem(m2.master),
    .inst_valid_o(v2), .inst_o(i2), .pcp_o(p2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; rst2 = 1'b1;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    m1.ack = 1'b1; m2.ack = 1'b1;
    step(); step();
    chk("rst_req",   32'(m1.req), 32'h0);
    chk("rst_addr",  32'(m1.addr), 32'h0);
    chk("rst_valid", 32'(v1), 32'h0);
    chk("rst_inst",  i1, 32'h0);
    chk("rst_pcp",   32'(p1), 32'h0);

    // Zero-wait streaming
    rst = 1'b0;
    step();
    chk("t1_req",   32'(m1.req), 32'h1);
    chk("t1_addr0", 32'(m1.addr), 32'h0);
    chk("t1_valid0", 32'(v1), 32'h0);
    step();
    chk("t1_inst0", i1, 32'h0);  chk("t1_pcp0", 32'(p1), 32'h4);
    chk("t1_v0", 32'(v1), 32'h1); chk("t1_addr4", 32'(m1.addr), 32'h4);
    step();
    chk("t1_inst4", i1, 32'h4);  chk("t1_pcp8", 32'(p1), 32'h8);
    step();
    chk("t1_inst8", i1, 32'h8);  chk("t1_pcp12", 32'(p1), 32'hC);
    chk("t1_addr12", 32'(m1.addr), 32'hC);

    // Stall three cycles: fetch 0xC parks in the skid, req drops
    stall = 1'b1;
    step();
    chk("t2_req0", 32'(m1.req), 32'h0); chk("t2_hold_inst", i1, 32'h8);
    chk("t2_hold_v", 32'(v1), 32'h1);
    step(); step();
    chk("t2_req0b", 32'(m1.req), 32'h0); chk("t2_hold_inst2", i1, 32'h8);
    stall = 1'b0;
    step();
    chk("t2_skid_inst", i1, 32'hC); chk("t2_skid_pcp", 32'(p1), 32'h10);
    chk("t2_req1", 32'(m1.req), 32'h1); chk("t2_addr16", 32'(m1.addr), 32'h10);
    step();
    chk("t2_inst16", i1, 32'h10); chk("t2_pcp20", 32'(p1), 32'h14);

    // Redirect while 0x8 is outstanding -> DROP
    rst = 1'b1;
    #1;
    chk("t3_async_v", 32'(v1), 32'h0); chk("t3_async_req", 32'(m1.req), 32'h0);
    step();
    rst = 1'b0;
    step(); step(); step();
    chk("t3_inst4", i1, 32'h4); chk("t3_addr8", 32'(m1.addr), 32'h8);
    m1.ack = 1'b0;
    step();
    chk("t3_v0", 32'(v1), 32'h0); chk("t3_addr8b", 32'(m1.addr), 32'h8);
    redirect = 1'b1; redirect_pc = 16'h0100;
    step();
    chk("t3_drop_addr", 32'(m1.addr), 32'h8); chk("t3_drop_req", 32'(m1.req), 32'h1);
    chk("t3_drop_v", 32'(v1), 32'h0);
    redirect = 1'b0; m1.ack = 1'b1;
    step();
    chk("t3_new_addr", 32'(m1.addr), 32'h100); chk("t3_nodata", 32'(v1), 32'h0);
    step();
    chk("t3_inst", i1, 32'h100); chk("t3_pcp", 32'(p1), 32'h104);
    chk("t3_v1", 32'(v1), 32'h1);

    // Two redirects during one DROP: latest target wins
    m1.ack = 1'b0; redirect = 1'b1; redirect_pc = 16'h0300;
    step();
    chk("t5_hold_addr", 32'(m1.addr), 32'h104); chk("t5_v0", 32'(v1), 32'h0);
    redirect_pc = 16'h0400;
    step();
    chk("t5_hold_addr2", 32'(m1.addr), 32'h104);
    redirect = 1'b0; m1.ack = 1'b1;
    step();
    chk("t5_new_addr", 32'(m1.addr), 32'h400); chk("t5_v0b", 32'(v1), 32'h0);
    step();
    chk("t5_inst", i1, 32'h400); chk("t5_pcp", 32'(p1), 32'h404);

    // Redirect with full skid while stalled: everything flushed
    stall = 1'b1;
    step();
    chk("t4_hold_req", 32'(m1.req), 32'h0); chk("t4_hold_inst", i1, 32'h400);
    redirect = 1'b1; redirect_pc = 16'h0200;
    step();
    chk("t4_v0", 32'(v1), 32'h0); chk("t4_req", 32'(m1.req), 32'h1);
    chk("t4_addr", 32'(m1.addr), 32'h200);
    redirect = 1'b0; stall = 1'b0;
    step();
    chk("t4_inst", i1, 32'h200); chk("t4_pcp", 32'(p1), 32'h204);
    step();
    chk("t4_inst2", i1, 32'h204); chk("t4_pcp2", 32'(p1), 32'h208);

    // Address wrap from RESET_PC=0xFFF8, then mid-stream async reset
    rst2 = 1'b0;
    step();
    chk("t6_addr", 32'(m2.addr), 32'hFFF8); chk("t6_req", 32'(m2.req), 32'h1);
    step();
    chk("t6_inst0", i2, 32'hFFF8); chk("t6_pcp0", 32'(p2), 32'hFFFC);
    step();
    chk("t6_inst1", i2, 32'hFFFC); chk("t6_pcp1", 32'(p2), 32'h0);
    chk("t6_addr_wrap", 32'(m2.addr), 32'h0);
    step();
    chk("t6_inst2", i2, 32'h0); chk("t6_pcp2", 32'(p2), 32'h4);
    #3;
    rst2 = 1'b1;
    #1;
    chk("t6_rst_req", 32'(m2.req), 32'h0); chk("t6_rst_addr", 32'(m2.addr), 32'h0);
    chk("t6_rst_v", 32'(v2), 32'h0); chk("t6_rst_inst", i2, 32'h0);
    chk("t6_rst_pcp", 32'(p2), 32'h0);
    step();
    rst2 = 1'b0;
    step();
    chk("t6_restart_addr", 32'(m2.addr), 32'hFFF8);
    step();
    chk("t6_restart_inst", i2, 32'hFFF8); chk("t6_restart_pcp", 32'(p2), 32'hFFFC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
